// File: rtl/syscall_unit.sv
// syscall_unit: execute-side service engine for SPIM-style syscalls.
// Freezes the pipeline while it services the code in $v0, using argument $a0.
// Output bytes leave through a valid/ready console port. String bytes are
// fetched through a one-request-at-a-time byte read port.
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   syscall_ex                    EX-stage instruction is SYSCALL
//   v0_value, a0_value            forwarded $v0 / $a0 for that instruction
//   stall, halt                   pipeline freeze / core halted by exit
//   console_valid, console_data   byte to emit (held until console_ready)
//   console_ready                 console accepts the byte this cycle
//   mem_req, mem_addr             one-cycle byte read request
//   mem_ack, mem_rdata            read response
module syscall_unit #(
   parameter logic [31:0] SYS_PRINT_INT    = 32'd1,
   parameter logic [31:0] SYS_PRINT_STRING = 32'd4,
   parameter logic [31:0] SYS_EXIT         = 32'd10,
   parameter logic [31:0] SYS_PRINT_CHAR   = 32'd11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        syscall_ex,
   input  logic [31:0] v0_value,
   input  logic [31:0] a0_value,
   output logic        stall,
   output logic        halt,
   output logic        console_valid,
   output logic [7:0]  console_data,
   input  logic        console_ready,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_DISPATCH  = 4'd1;
   localparam logic [3:0] S_INT_SIGN  = 4'd2;
   localparam logic [3:0] S_INT_DIGIT = 4'd3;
   localparam logic [3:0] S_EMIT      = 4'd4;
   localparam logic [3:0] S_STR_REQ   = 4'd5;
   localparam logic [3:0] S_STR_WAIT  = 4'd6;
   localparam logic [3:0] S_DONE      = 4'd7;
   localparam logic [3:0] S_HALTED    = 4'd8;

   logic [3:0]  state_q, state_d;
   logic [3:0]  ret_q, ret_d;       // state to resume after EMIT
   logic [31:0] v0_q, v0_d;
   logic [31:0] a0_q, a0_d;
   logic        neg_q, neg_d;
   logic [31:0] mag_q, mag_d;
   logic [3:0]  k_q, k_d;
   logic        started_q, started_d;
   logic [31:0] ptr_q, ptr_d;
   logic [7:0]  char_q, char_d;

   // Decimal digit extraction: largest d in 0..9 with d*10^k <= mag.
   // Products are 36 bits wide because 9*10^9 does not fit in 32.
   logic [35:0] pow_w;
   logic [35:0] prod_w;
   logic [35:0] sub_w;
   logic [3:0]  digit_w;

   always_comb begin
      case (k_q)
         4'd0:    pow_w = 36'd1;
         4'd1:    pow_w = 36'd10;
         4'd2:    pow_w = 36'd100;
         4'd3:    pow_w = 36'd1000;
         4'd4:    pow_w = 36'd10000;
         4'd5:    pow_w = 36'd100000;
         4'd6:    pow_w = 36'd1000000;
         4'd7:    pow_w = 36'd10000000;
         4'd8:    pow_w = 36'd100000000;
         4'd9:    pow_w = 36'd1000000000;
         default: pow_w = 36'd1;
      endcase
   end

   always_comb begin
      digit_w = 4'd0;
      sub_w   = 36'd0;
      prod_w  = 36'd0;
      for (int unsigned i = 1; i < 10; i++) begin
         prod_w = 36'(i) * pow_w;
         if ({4'd0, mag_q} >= prod_w) begin
            digit_w = 4'(i);
            sub_w   = prod_w;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      v0_d      = v0_q;
      a0_d      = a0_q;
      neg_d     = neg_q;
      mag_d     = mag_q;
      k_d       = k_q;
      started_d = started_q;
      ptr_d     = ptr_q;
      char_d    = char_q;
      case (state_q)
         S_IDLE: begin
            if (syscall_ex) begin
               v0_d    = v0_value;
               a0_d    = a0_value;
               state_d = S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            if (v0_q == SYS_PRINT_CHAR) begin
               char_d  = a0_q[7:0];
               ret_d   = S_DONE;
               state_d = S_EMIT;
            end else if (v0_q == SYS_PRINT_INT) begin
               neg_d     = a0_q[31];
               mag_d     = a0_q[31] ? (~a0_q + 32'd1) : a0_q;
               k_d       = 4'd9;
               started_d = 1'b0;
               state_d   = S_INT_SIGN;
            end else if (v0_q == SYS_PRINT_STRING) begin
               ptr_d   = a0_q;
               state_d = S_STR_REQ;
            end else if (v0_q == SYS_EXIT) begin
               state_d = S_HALTED;
            end else begin
               state_d = S_DONE;
            end
         end
         S_INT_SIGN: begin
            if (neg_q) begin
               char_d  = 8'h2D;
               ret_d   = S_INT_DIGIT;
               state_d = S_EMIT;
            end else begin
               state_d = S_INT_DIGIT;
            end
         end
         S_INT_DIGIT: begin
            mag_d = mag_q - 32'(sub_w);
            if (k_q != 4'd0) begin
               k_d = k_q - 4'd1;
            end
            if (digit_w != 4'd0 || started_q || k_q == 4'd0) begin
               started_d = 1'b1;
               char_d    = 8'h30 + {4'd0, digit_w};
               ret_d     = (k_q == 4'd0) ? S_DONE : S_INT_DIGIT;
               state_d   = S_EMIT;
            end else begin
               state_d = (k_q == 4'd0) ? S_DONE : S_INT_DIGIT;
            end
         end
         S_EMIT: begin
            if (console_ready) begin
               state_d = ret_q;
            end
         end
         S_STR_REQ: begin
            state_d = S_STR_WAIT;
         end
         S_STR_WAIT: begin
            if (mem_ack) begin
               if (mem_rdata == 8'd0) begin
                  state_d = S_DONE;
               end else begin
                  char_d  = mem_rdata;
                  ptr_d   = ptr_q + 32'd1;
                  ret_d   = S_STR_REQ;
                  state_d = S_EMIT;
               end
            end
         end
         // The instruction retires here; syscall_ex still refers to it.
         S_DONE:   state_d = S_IDLE;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ret_q     <= S_DONE;
         v0_q      <= 32'd0;
         a0_q      <= 32'd0;
         neg_q     <= 1'b0;
         mag_q     <= 32'd0;
         k_q       <= 4'd0;
         started_q <= 1'b0;
         ptr_q     <= 32'd0;
         char_q    <= 8'd0;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         v0_q      <= v0_d;
         a0_q      <= a0_d;
         neg_q     <= neg_d;
         mag_q     <= mag_d;
         k_q       <= k_d;
         started_q <= started_d;
         ptr_q     <= ptr_d;
         char_q    <= char_d;
      end
   end

   // Combinational so the first cycle of a syscall is already frozen.
   assign stall = ((state_q == S_IDLE) && syscall_ex) ||
                  ((state_q != S_IDLE) && (state_q != S_DONE));
   assign halt          = (state_q == S_HALTED);
   assign console_valid = (state_q == S_EMIT);
   assign console_data  = char_q;
   assign mem_req       = (state_q == S_STR_REQ);
   assign mem_addr      = ptr_q;

endmodule
